game_select_ctrl: RTL

GAME_SELECT_CTRL -- requirements
Module: game_select_ctrl

---
 rtl/game_select_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/game_select_ctrl.sv
// Game selection controller: debounces the slide-switch request, then sequences
// blank -> hold all games in reset -> release the chosen game, all paced by vsync frames.
module game_select_ctrl #(
  parameter int STABLE_FRAMES = 4,
  parameter int BLANK_FRAMES  = 8,
  parameter int RST_FRAMES    = 2
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic [2:0] ctrl,
  input  logic       vsync,
  output logic [2:0] game_sel,
  output logic [4:0] game_rst,
  output logic       blank,
  output logic       busy
);

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_FRAMES = max_i(max_i(STABLE_FRAMES, BLANK_FRAMES), RST_FRAMES);
  localparam int CNT_W      = (MAX_FRAMES < 1) ? 1 : $clog2(MAX_FRAMES + 1);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_FRAMES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST  = CNT_W'(BLANK_FRAMES - 1);
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FADE,
    ST_HOLD,
    ST_RELEASE
  } state_t;

  // Codes 110/111 have no game behind them and fall back to the menu.
  function automatic logic [2:0] map_req(input logic [2:0] code);
    return (code[2] && code[1]) ? 3'b000 : code;
  endfunction

  // Reset vector with only the selected game's bit cleared; {dino, ttt, dg, pp, dc}.
  function automatic logic [4:0] rst_decode(input logic [2:0] sel);
    logic [4:0] v;
    case (sel)
      3'b001:  v = 5'b01111;
      3'b010:  v = 5'b10111;
      3'b011:  v = 5'b11011;
      3'b100:  v = 5'b11101;
      3'b101:  v = 5'b11110;
      default: v = 5'b11111;
    endcase
    return v;
  endfunction

  logic [2:0]       ctrl_p0, ctrl_p1;
  logic             vsync_p0, vsync_p1, vsync_p2;
  logic             frame_tick;

  logic [2:0]       req, req_d;
  logic             req_changed, req_differs, deb_done;
  logic [CNT_W-1:0] deb_cnt, deb_cnt_nxt;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] frame_cnt, frame_cnt_nxt;
  logic [2:0]       target, target_nxt;
  logic [2:0]       game_sel_nxt;
  logic [4:0]       game_rst_nxt;

  // Stage p0/p1: two-flop synchronizers; p2 holds the previous vsync for edge detection
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_p0  <= 3'b000;
      ctrl_p1  <= 3'b000;
      vsync_p0 <= 1'b0;
      vsync_p1 <= 1'b0;
      vsync_p2 <= 1'b0;
    end else begin
      ctrl_p0  <= ctrl;
      ctrl_p1  <= ctrl_p0;
      vsync_p0 <= vsync;
      vsync_p1 <= vsync_p0;
      vsync_p2 <= vsync_p1;
    end
  end

  assign frame_tick = vsync_p2 & ~vsync_p1;

  // Debounce: the request must stay put and differ from the running game
  assign req         = map_req(ctrl_p1);
  assign req_changed = (req != req_d);
  assign req_differs = (req != game_sel);
  assign deb_done    = (state == ST_RUN) && !req_changed && req_differs &&
                       frame_tick && (deb_cnt == STABLE_LAST);

  always_comb begin
    deb_cnt_nxt = deb_cnt;
    if ((state != ST_RUN) || req_changed || !req_differs || deb_done) begin
      deb_cnt_nxt = '0;
    end else if (frame_tick) begin
      deb_cnt_nxt = deb_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      req_d   <= 3'b000;
      deb_cnt <= '0;
    end else begin
      req_d   <= req;
      deb_cnt <= deb_cnt_nxt;
    end
  end

  // Transition sequencer: counters advance only on frame ticks, so a stopped vsync stalls it
  always_comb begin
    state_nxt     = state;
    frame_cnt_nxt = frame_cnt;
    target_nxt    = target;
    game_sel_nxt  = game_sel;
    game_rst_nxt  = game_rst;
    case (state)
      ST_RUN: begin
        if (deb_done) begin
          state_nxt     = ST_FADE;
          target_nxt    = req;
          frame_cnt_nxt = '0;
        end
      end
      ST_FADE: begin
        if (frame_tick) begin
          if (frame_cnt == BLANK_LAST) begin
            state_nxt     = ST_HOLD;
            frame_cnt_nxt = '0;
            game_sel_nxt  = target;
            game_rst_nxt  = 5'b11111;
          end else begin
            frame_cnt_nxt = frame_cnt + CNT_W'(1);
          end
        end
      end
      ST_HOLD: begin
        if (frame_tick) begin
          if (frame_cnt == RST_LAST) begin
            state_nxt     = ST_RELEASE;
            frame_cnt_nxt = '0;
            game_rst_nxt  = rst_decode(game_sel);
          end else begin
            frame_cnt_nxt = frame_cnt + CNT_W'(1);
          end
        end
      end
      ST_RELEASE: begin
        state_nxt = ST_RUN;
      end
      default: begin
        state_nxt     = ST_RUN;
        frame_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      frame_cnt <= '0;
      target    <= 3'b000;
      game_sel  <= 3'b000;
      game_rst  <= 5'b11111;
      blank     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      frame_cnt <= frame_cnt_nxt;
      target    <= target_nxt;
      game_sel  <= game_sel_nxt;
      game_rst  <= game_rst_nxt;
      blank     <= (state_nxt != ST_RUN);
      busy      <= (state_nxt != ST_RUN);
    end
  end

endmodule
